stream_packer: RTL

Sequential, parametrised packer that assembles a stream of narrow multi-lane output beats into full memory words. It sits between the output stage (requantised activations) and the output SRAM/external write port. Each accepted beat fills the next slot of a word; the first beat's lane 0 lands in the word's MSBs. A last-flag forces early emission of a partial word. Both sides use a valid/ready handshake.

---
 rtl/packer_pkg.sv | 17 +
 rtl/lane_inserter.sv | 50 +++++
 rtl/stream_packer.sv | 107 ++++++++++
 3 files changed

// File: rtl/packer_pkg.sv
// Shared constants and sizing helpers for stream_packer and its lane inserter.
// The optional byte mask is controlled by STREAM_PACKER_BYTE_MASK_EN in the users of this package.
package packer_pkg;

    localparam int DEF_IO_DATA_WIDTH = 8;
    localparam int DEF_LANES_IN      = 4;
    localparam int DEF_MEM_BW        = 128;

    function automatic int beats_per_word(input int w, input int lanes, input int bw);
        return bw / (w * lanes);
    endfunction

    function automatic int slot_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/lane_inserter.sv
// Combinational merge of one multi-lane beat into the accumulation word at a given slot.
// With STREAM_PACKER_BYTE_MASK_EN defined, also marks the written bytes in a parallel mask.
module lane_inserter
    import packer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
    parameter int LANES_IN      = DEF_LANES_IN,
    parameter int MEM_BW        = DEF_MEM_BW,
    localparam int BEATS        = beats_per_word(IO_DATA_WIDTH, LANES_IN, MEM_BW),
    localparam int SW           = slot_width(BEATS)
) (
    input  logic [MEM_BW-1:0]        acc,
    input  logic [IO_DATA_WIDTH-1:0] beat [0:LANES_IN-1],
    input  logic [SW-1:0]            slot,
`ifdef STREAM_PACKER_BYTE_MASK_EN
    input  logic [MEM_BW/8-1:0]      acc_mask,
    output logic [MEM_BW/8-1:0]      next_mask,
`endif
    output logic [MEM_BW-1:0]        next_word
);

    // Lane 0 of slot 0 occupies the MSBs; later lanes and slots walk toward the LSBs.
    always_comb begin
        // NOTE: default to the incoming accumulation first so every path assigns next_word (no latch).
        next_word = acc;
        for (int k = 0; k < BEATS; k++) begin
            if (slot == SW'(k)) begin
                for (int j = 0; j < LANES_IN; j++) begin
                    next_word[MEM_BW-1-(k*LANES_IN+j)*IO_DATA_WIDTH -: IO_DATA_WIDTH] = beat[j];
                end
            end
        end
    end

`ifdef STREAM_PACKER_BYTE_MASK_EN
    localparam int BPL = IO_DATA_WIDTH / 8;

    always_comb begin
        next_mask = acc_mask;
        for (int k = 0; k < BEATS; k++) begin
            if (slot == SW'(k)) begin
                for (int j = 0; j < LANES_IN; j++) begin
                    next_mask[MEM_BW/8-1-(k*LANES_IN+j)*BPL -: BPL] = '1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/stream_packer.sv
// Packs narrow multi-lane beats into MEM_BW-wide words with valid/ready on both sides.
// Define STREAM_PACKER_BYTE_MASK_EN to add the registered out_mask byte-enable port.
module stream_packer
    import packer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
    parameter int LANES_IN      = DEF_LANES_IN,
    parameter int MEM_BW        = DEF_MEM_BW
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [IO_DATA_WIDTH-1:0] in_data [0:LANES_IN-1],
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [MEM_BW-1:0]        out_data,
    output logic                     out_last,
    output logic                     out_valid,
`ifdef STREAM_PACKER_BYTE_MASK_EN
    output logic [MEM_BW/8-1:0]      out_mask,
`endif
    input  logic                     out_ready
);

    localparam int BEATS = beats_per_word(IO_DATA_WIDTH, LANES_IN, MEM_BW);
    localparam int SW    = slot_width(BEATS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(BEATS - 1);

    if (MEM_BW % (IO_DATA_WIDTH * LANES_IN) != 0) begin : g_bad_mem_bw
        $error("stream_packer: MEM_BW must be a multiple of IO_DATA_WIDTH*LANES_IN");
    end
`ifdef STREAM_PACKER_BYTE_MASK_EN
    if (IO_DATA_WIDTH % 8 != 0) begin : g_bad_lane_width
        $error("stream_packer: byte mask needs IO_DATA_WIDTH to be a multiple of 8");
    end
`endif

    logic [SW-1:0]     slot;
    logic [MEM_BW-1:0] acc;
    logic [MEM_BW-1:0] next_word;
    logic              closing;
    logic              accept;

`ifdef STREAM_PACKER_BYTE_MASK_EN
    logic [MEM_BW/8-1:0] acc_mask;
    logic [MEM_BW/8-1:0] next_mask;
`endif

    lane_inserter #(
        .IO_DATA_WIDTH (IO_DATA_WIDTH),
        .LANES_IN      (LANES_IN),
        .MEM_BW        (MEM_BW)
    ) u_lane_inserter (
        .acc       (acc),
        .beat      (in_data),
        .slot      (slot),
`ifdef STREAM_PACKER_BYTE_MASK_EN
        .acc_mask  (acc_mask),
        .next_mask (next_mask),
`endif
        .next_word (next_word)
    );

    // Only a closing beat needs the output register; everything else lands in acc.
    assign closing  = (slot == LAST_SLOT) || in_last;
    assign in_ready = !out_valid || out_ready || !closing;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            slot      <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
`ifdef STREAM_PACKER_BYTE_MASK_EN
            acc_mask  <= '0;
            out_mask  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values; a close below overrides the drain.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (closing) begin
                    out_data  <= next_word;
                    out_last  <= in_last;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    slot      <= '0;
`ifdef STREAM_PACKER_BYTE_MASK_EN
                    out_mask  <= next_mask;
                    acc_mask  <= '0;
`endif
                end else begin
                    acc       <= next_word;
                    slot      <= slot + SW'(1);
`ifdef STREAM_PACKER_BYTE_MASK_EN
                    acc_mask  <= next_mask;
`endif
                end
            end
        end
    end

endmodule
